// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide unit.
// Contents: default XLEN, RV32M funct3 encodings, muldiv FSM state type.
package riscv_pkg;

    parameter int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iteration datapath for muldiv_unit: shared 2*XLEN accumulator, partial
// remainder and step counter. Operands arrive as unsigned magnitudes.
// Optional macro MULDIV_FAST_MUL_EN: multiplies load the full product at start.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        load operands (clears counter and remainder)
//   step         perform one iteration
//   is_div       1 = restoring division, 0 = shift-add multiply
//   op_a, op_b   magnitudes (multiplicand/multiplier or dividend/divisor)
//   prod         2*XLEN product
//   quot, rem    quotient and remainder
//   last         asserted while the final iteration is being performed
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] prod,
    output logic [XLEN-1:0]   quot,
    output logic [XLEN-1:0]   rem,
    output logic              last
);

    localparam int unsigned CntW = $clog2(XLEN);

    // acc_q: {high partial sum, multiplier} for multiply; low half is the
    // dividend/quotient shifter for divide. opnd_q holds the multiplicand or
    // the divisor, whichever the operation needs.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              div_q, div_d;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;

    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        trial   = {rem_q, acc_q[XLEN-1]};
        diff    = trial - {1'b0, opnd_q};

        if (start) begin
            cnt_d = '0;
            rem_d = '0;
            div_d = is_div;
            if (is_div) begin
                acc_d  = {{XLEN{1'b0}}, op_a};
                opnd_d = op_b;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc_d  = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
`else
                acc_d  = {{XLEN{1'b0}}, op_b};
`endif
                opnd_d = op_a;
            end
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                // Restoring step: keep the trial remainder only if it did not go negative.
                if (diff[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                end else begin
                    rem_d = diff[XLEN-1:0];
                end
                acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN]};
            end else begin
                if (acc_q[0]) begin
                    acc_d = {add_sum, acc_q[XLEN-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign prod = acc_q;
    assign quot = acc_q[XLEN-1:0];
    assign rem  = rem_q;
    assign last = step && (cnt_q == CntW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL* ops.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   StartE         M-extension op present in EX
//   KillE          flush; aborts any operation
//   Funct3E        RV32M funct3
//   SrcAE, SrcBE   forwarded rs1/rs2
//   BusyE          stall request to the hazard unit
//   DoneE          one-cycle result-valid pulse
//   MulDivResultE  result, held until the next accepted start
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic            KillE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] MulDivResultE
);

    muldiv_state_e   state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            is_div;
    logic            sign_a, sign_b;
    logic            mag_a_en, mag_b_en;
    logic            res_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic              core_start, core_step, core_last;
    logic [2*XLEN-1:0] core_prod, prod_fix;
    logic [XLEN-1:0]   core_quot, core_rem, quot_fix, rem_fix, fix_res;

    // Operand decode for the op being offered this cycle.
    always_comb begin
        is_div   = Funct3E[2];
        sign_a   = SrcAE[XLEN-1];
        sign_b   = SrcBE[XLEN-1];
        mag_a_en = 1'b0;
        mag_b_en = 1'b0;
        res_neg  = 1'b0;
        case (Funct3E)
            F3_MUL, F3_MULH, F3_DIV: begin
                mag_a_en = sign_a;
                mag_b_en = sign_b;
                res_neg  = sign_a ^ sign_b;
            end
            F3_MULHSU: begin
                mag_a_en = sign_a;
                res_neg  = sign_a;
            end
            F3_REM: begin
                mag_a_en = sign_a;
                mag_b_en = sign_b;
                res_neg  = sign_a;
            end
            default: ;
        endcase
        mag_a = mag_a_en ? (~SrcAE + 1'b1) : SrcAE;
        mag_b = mag_b_en ? (~SrcBE + 1'b1) : SrcBE;

        div_zero = is_div && (SrcBE == '0);
        div_ovf  = ((Funct3E == F3_DIV) || (Funct3E == F3_REM)) &&
                   (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
        special  = div_zero || div_ovf;
        // Funct3E[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = Funct3E[1] ? SrcAE : '1;
        end else begin
            special_res = Funct3E[1] ? '0 : SrcAE;
        end
    end

    // Sign fix and result select for the registered op.
    always_comb begin
        prod_fix = neg_q ? (~core_prod + 1'b1) : core_prod;
        quot_fix = neg_q ? (~core_quot + 1'b1) : core_quot;
        rem_fix  = neg_q ? (~core_rem + 1'b1) : core_rem;
        if (funct3_q[2]) begin
            fix_res = funct3_q[1] ? rem_fix : quot_fix;
        end else if (funct3_q[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign accept = (state_q == IDLE) && StartE && !KillE;

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        neg_d      = neg_q;
        result_d   = result_q;
        core_start = 1'b0;
        core_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = Funct3E;
                    neg_d    = res_neg;
                    if (special) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        core_start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state_d = is_div ? CALC : FIX;
`else
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d  = DONE;
                result_d = fix_res;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush abandons the op; the last delivered result stays visible.
        if (KillE) begin
            state_d   = IDLE;
            result_d  = result_q;
            core_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .step   (core_step),
        .is_div (is_div),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .prod   (core_prod),
        .quot   (core_quot),
        .rem    (core_rem),
        .last   (core_last)
    );

    assign BusyE         = rst_n && (accept || (state_q == CALC) || (state_q == FIX));
    assign DoneE         = (state_q == DONE);
    assign MulDivResultE = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;
    import riscv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 34;
`endif
    localparam int DivLat = 34;
    localparam int SpcLat = 1;

    logic        clk;
    logic        rst_n;
    logic        StartE;
    logic        KillE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] MulDivResultE;

    int checks;
    int failures;
    logic [31:0] last_res;

    muldiv_unit #(
        .XLEN (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StartE        (StartE),
        .KillE         (KillE),
        .Funct3E       (Funct3E),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .BusyE         (BusyE),
        .DoneE         (DoneE),
        .MulDivResultE (MulDivResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle. Drives one op, optionally pokes a
    // stray StartE at cycle offset stray_at (0 = none), and checks latency,
    // busy cycle count and result. Returns at the negedge after DoneE.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int stray_at);
        int lat;
        int busy_cnt;
        StartE  = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        #1;
        check({tag, " busy@T"}, {31'd0, BusyE}, 32'd1);
        busy_cnt = 1;
        lat = 0;
        @(negedge clk);
        StartE = 1'b0;
        lat = 1;
        while (!DoneE && lat < 100) begin
            if (lat == stray_at) begin
                StartE  = 1'b1;
                Funct3E = F3_MUL;
                SrcAE   = 32'd3;
                SrcBE   = 32'd3;
                #1;
            end
            if (BusyE) busy_cnt++;
            @(negedge clk);
            StartE = 1'b0;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " result"}, MulDivResultE, exp_res);
        check({tag, " busy@done"}, {31'd0, BusyE}, 32'd0);
        last_res = exp_res;
        @(negedge clk);
        check({tag, " done pulse"}, {31'd0, DoneE}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_res = '0;
        rst_n    = 1'b0;
        StartE   = 1'b0;
        KillE    = 1'b0;
        Funct3E  = '0;
        SrcAE    = '0;
        SrcBE    = '0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, BusyE}, 32'd0);
        check("rst done", {31'd0, DoneE}, 32'd0);
        check("rst result", MulDivResultE, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies.
        do_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat, 0);
        do_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 0);
        do_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MulLat, 0);
        do_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat, 0);
        do_op("mulh neg", F3_MULH, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, MulLat, 0);

        // Divides.
        do_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivLat, 0);
        do_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivLat, 0);
        do_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, DivLat, 0);
        do_op("remu", F3_REMU, 32'd100, 32'd7, 32'd2, DivLat, 0);
        do_op("divu big", F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, DivLat, 0);

        // Special cases.
        do_op("divu by0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SpcLat, 0);
        do_op("rem by0", F3_REM, 32'd5, 32'd0, 32'd5, SpcLat, 0);
        do_op("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpcLat, 0);
        do_op("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpcLat, 0);

        // Kill mid-divide at T+10, restart at T+11.
        StartE  = 1'b1;
        Funct3E = F3_DIV;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd3;
        @(negedge clk);
        StartE = 1'b0;
        repeat (9) @(negedge clk);
        KillE = 1'b1;
        #1;
        check("kill done@T+10", {31'd0, DoneE}, 32'd0);
        @(negedge clk);
        KillE = 1'b0;
        #1;
        check("kill busy@T+11", {31'd0, BusyE}, 32'd0);
        check("kill done@T+11", {31'd0, DoneE}, 32'd0);
        check("kill result held", MulDivResultE, last_res);
        do_op("after kill", F3_DIVU, 32'd1000, 32'd3, 32'd333, DivLat, 0);

        // Start with kill in IDLE is not accepted.
        StartE  = 1'b1;
        KillE   = 1'b1;
        Funct3E = F3_DIVU;
        SrcAE   = 32'd9;
        SrcBE   = 32'd0;
        #1;
        check("startkill busy", {31'd0, BusyE}, 32'd0);
        @(negedge clk);
        StartE = 1'b0;
        KillE  = 1'b0;
        #1;
        check("startkill busy+1", {31'd0, BusyE}, 32'd0);
        check("startkill done+1", {31'd0, DoneE}, 32'd0);
        check("startkill result", MulDivResultE, last_res);
        @(negedge clk);

        // Stray StartE during CALC is ignored.
        do_op("stray", F3_DIVU, 32'd100, 32'd7, 32'd14, DivLat, 5);

        // Reset mid-multiply.
        do_op("pre-rst", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 0);
        StartE  = 1'b1;
        Funct3E = F3_MUL;
        SrcAE   = 32'd11;
        SrcBE   = 32'd13;
        @(negedge clk);
        StartE = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst busy@T+5", {31'd0, BusyE}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst busy after", {31'd0, BusyE}, 32'd0);
        check("rst done after", {31'd0, DoneE}, 32'd0);
        check("rst result after", MulDivResultE, 32'd0);
        @(negedge clk);
        do_op("after rst", F3_MUL, 32'd11, 32'd13, 32'd143, MulLat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
